// File: rtl/wfq_pkg.sv
// Shared defaults and FSM state type for the WFQ egress reader and its counter bank.
package wfq_pkg;

    localparam int WFQ_NUM_FLOWS  = 16;
    localparam int WFQ_RD_LATENCY = 7;
    localparam int WFQ_DATA_W     = 64;
    localparam int WFQ_CNT_W      = 32;
    localparam int WFQ_BAD_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } wfq_state_e;

endpackage

// File: rtl/wfq_flow_counter_bank.sv
// Per-flow saturating word counters with total/bad-flow counters and a registered readback mux.
module wfq_flow_counter_bank
    import wfq_pkg::*;
#(
    parameter int NUM_FLOWS = WFQ_NUM_FLOWS,
    parameter int CNT_W     = WFQ_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clear,
    input  logic                         i_cap,
    input  logic                         i_valid,
    input  logic [$clog2(NUM_FLOWS)-1:0] i_idx,
    input  logic [$clog2(NUM_FLOWS)-1:0] i_sel,
    output logic [CNT_W-1:0]             o_cnt_value,
    output logic [CNT_W-1:0]             o_total,
    output logic [WFQ_BAD_W-1:0]         o_bad
);

    localparam int SEL_W = $clog2(NUM_FLOWS);

    logic [CNT_W-1:0] r_cnt [NUM_FLOWS];
    logic             w_hit_valid;
    logic             w_hit_bad;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [WFQ_BAD_W-1:0] sat_inc_bad(input logic [WFQ_BAD_W-1:0] v);
        return (&v) ? v : v + WFQ_BAD_W'(1);
    endfunction

    assign w_hit_valid = i_cap && i_valid;
    assign w_hit_bad   = i_cap && !i_valid;

    // A clear coinciding with a capture zeroes first, so the captured word counts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FLOWS; i++) r_cnt[i] <= '0;
            o_total     <= '0;
            o_bad       <= '0;
            o_cnt_value <= '0;
        end else begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                if (w_hit_valid && (i_idx == SEL_W'(i)))
                    r_cnt[i] <= sat_inc_cnt(i_clear ? '0 : r_cnt[i]);
                else if (i_clear)
                    r_cnt[i] <= '0;
            end
            if (w_hit_valid)  o_total <= sat_inc_cnt(i_clear ? '0 : o_total);
            else if (i_clear) o_total <= '0;
            if (w_hit_bad)    o_bad <= sat_inc_bad(i_clear ? '0 : o_bad);
            else if (i_clear) o_bad <= '0;
            o_cnt_value <= r_cnt[i_sel];
        end
    end

endmodule

// File: rtl/wfq_egress_reader.sv
// Paced read-request generator for the WFQ scheduler; tracks read latency and bins returned words by flow.
module wfq_egress_reader
    import wfq_pkg::*;
#(
    parameter int NUM_FLOWS  = WFQ_NUM_FLOWS,
    parameter int RD_LATENCY = WFQ_RD_LATENCY,
    parameter int DATA_W     = WFQ_DATA_W,
    parameter int CNT_W      = WFQ_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_enable,
    input  logic [7:0]                   in_rd_gap,
    input  logic                         in_buffer_empty,
    output logic                         out_rd_packet_req,
    input  logic [DATA_W-1:0]            in_packet_data,
    input  logic                         in_clear,
    input  logic [$clog2(NUM_FLOWS)-1:0] in_cnt_sel,
    output logic [CNT_W-1:0]             out_cnt_value,
    output logic [CNT_W-1:0]             out_total_words,
    output logic [WFQ_BAD_W-1:0]         out_bad_flow_cnt,
    output logic                         out_busy
);

    localparam int SEL_W = $clog2(NUM_FLOWS);

    wfq_state_e            r_state;
    wfq_state_e            w_state_nxt;
    logic [7:0]            r_gap_cnt;
    logic [RD_LATENCY-1:0] r_req_sr;
    logic                  w_capture;
    logic                  w_valid;
    logic [SEL_W-1:0]      w_flow_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_enable && !in_buffer_empty) w_state_nxt = ST_REQ;
            ST_REQ:  w_state_nxt = ST_GAP;
            ST_GAP:  if (r_gap_cnt <= 8'd1) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        out_rd_packet_req = (r_state == ST_REQ);
    end

    // Gap length is latched while leaving REQ; a programmed gap of 0 behaves as 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_gap_cnt <= '0;
        else if (r_state == ST_REQ) r_gap_cnt <= (in_rd_gap == 8'd0) ? 8'd1 : in_rd_gap;
        else if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt - 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_req_sr <= '0;
        else        r_req_sr <= (r_req_sr << 1) | RD_LATENCY'(out_rd_packet_req);
    end

    assign w_capture  = r_req_sr[RD_LATENCY-1];
    assign w_valid    = (in_packet_data < DATA_W'(NUM_FLOWS));
    assign w_flow_idx = in_packet_data[SEL_W-1:0];
    assign out_busy   = |r_req_sr;

    wfq_flow_counter_bank #(
        .NUM_FLOWS (NUM_FLOWS),
        .CNT_W     (CNT_W)
    ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (in_clear),
        .i_cap       (w_capture),
        .i_valid     (w_valid),
        .i_idx       (w_flow_idx),
        .i_sel       (in_cnt_sel),
        .o_cnt_value (out_cnt_value),
        .o_total     (out_total_words),
        .o_bad       (out_bad_flow_cnt)
    );

endmodule

// File: tb/tb_wfq_egress_reader.sv
// Directed bench: scheduler model returns a programmable word RD_LATENCY cycles after each request.
module tb_wfq_egress_reader;

    localparam int TB_CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_enable;
    logic [7:0]  in_rd_gap;
    logic        in_buffer_empty;
    logic        out_rd_packet_req;
    logic [63:0] in_packet_data;
    logic        in_clear;
    logic [3:0]  in_cnt_sel;
    logic [TB_CNT_W-1:0] out_cnt_value;
    logic [TB_CNT_W-1:0] out_total_words;
    logic [15:0] out_bad_flow_cnt;
    logic        out_busy;

    logic [63:0] ret_val;
    logic [6:0]  tb_pipe = '0;
    int          cyc = 0;
    int          req_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          base;

    wfq_egress_reader #(
        .NUM_FLOWS (16),
        .RD_LATENCY(7),
        .DATA_W    (64),
        .CNT_W     (TB_CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_enable        (in_enable),
        .in_rd_gap        (in_rd_gap),
        .in_buffer_empty  (in_buffer_empty),
        .out_rd_packet_req(out_rd_packet_req),
        .in_packet_data   (in_packet_data),
        .in_clear         (in_clear),
        .in_cnt_sel       (in_cnt_sel),
        .out_cnt_value    (out_cnt_value),
        .out_total_words  (out_total_words),
        .out_bad_flow_cnt (out_bad_flow_cnt),
        .out_busy         (out_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scheduler model: word is valid only in the cycle RD_LATENCY after a request, junk otherwise.
    always @(posedge clk) tb_pipe <= {tb_pipe[5:0], out_rd_packet_req};
    assign in_packet_data = tb_pipe[6] ? ret_val : 64'hDEAD_0020;

    always @(negedge clk) if (out_rd_packet_req === 1'b1) req_q.push_back(cyc);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue_req(input int n);
        int target;
        int guard;
        target = req_q.size() + n;
        guard = 0;
        in_enable = 1'b1;
        while (req_q.size() < target && guard < 400) begin
            @(negedge clk); #1;
            guard++;
        end
        in_enable = 1'b0;
        if (req_q.size() < target) check("req_timeout", 64'(req_q.size()), 64'(target));
    endtask

    task automatic read_cnt(input logic [3:0] sel, input logic [3:0] exp, input string tag);
        in_cnt_sel = sel;
        @(negedge clk); #1;
        check(tag, 64'(out_cnt_value), 64'(exp));
    endtask

    initial begin
        rst_n = 1'b0; in_enable = 1'b0; in_rd_gap = 8'd3; in_buffer_empty = 1'b0;
        in_clear = 1'b0; in_cnt_sel = 4'd0; ret_val = 64'd5;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req",   64'(out_rd_packet_req), 64'd0);
        check("rst_busy",  64'(out_busy),          64'd0);
        check("rst_cnt",   64'(out_cnt_value),     64'd0);
        check("rst_total", 64'(out_total_words),   64'd0);
        check("rst_bad",   64'(out_bad_flow_cnt),  64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // Ten requests with gap 3: period 5, flow 5 each time
        base = req_q.size();
        issue_req(10);
        for (int i = 1; i < 10; i++)
            check("period_gap3", 64'(req_q[base+i] - req_q[base+i-1]), 64'd5);
        repeat (7) @(negedge clk); #1;
        check("busy_last_minus1", 64'(out_busy), 64'd1);
        @(negedge clk); #1;
        check("busy_cleared", 64'(out_busy), 64'd0);
        check("no_extra_req", 64'(req_q.size() - base), 64'd10);
        read_cnt(4'd5, 4'd10, "cnt5_after10");
        read_cnt(4'd4, 4'd0,  "cnt4_zero");
        check("total_after10", 64'(out_total_words),  64'd10);
        check("bad_after10",   64'(out_bad_flow_cnt), 64'd0);

        // Out-of-range words: 16 and 0x20 are bad, 15 is the last valid flow
        ret_val = 64'd16;
        issue_req(1);
        repeat (10) @(negedge clk); #1;
        check("bad_16",       64'(out_bad_flow_cnt), 64'd1);
        check("total_no_inc", 64'(out_total_words),  64'd10);
        ret_val = 64'h20;
        issue_req(1);
        repeat (10) @(negedge clk); #1;
        check("bad_0x20", 64'(out_bad_flow_cnt), 64'd2);
        ret_val = 64'd15;
        issue_req(1);
        repeat (10) @(negedge clk); #1;
        check("total_flow15", 64'(out_total_words), 64'd11);
        read_cnt(4'd15, 4'd1, "cnt15");

        // Clear in the same cycle as the capture of flow 2
        ret_val = 64'd2;
        issue_req(1);
        repeat (7) @(negedge clk);
        in_clear = 1'b1;
        @(negedge clk);
        in_clear = 1'b0;
        repeat (2) @(negedge clk); #1;
        check("clr_total", 64'(out_total_words),  64'd1);
        check("clr_bad",   64'(out_bad_flow_cnt), 64'd0);
        read_cnt(4'd2,  4'd1, "clr_cnt2");
        read_cnt(4'd5,  4'd0, "clr_cnt5");
        read_cnt(4'd15, 4'd0, "clr_cnt15");

        // Gap 0 behaves as 1; twenty flow-7 words saturate the 4-bit counters
        in_rd_gap = 8'd0;
        ret_val = 64'd7;
        base = req_q.size();
        issue_req(20);
        check("period_gap0_a", 64'(req_q[base+1] - req_q[base]),   64'd3);
        check("period_gap0_b", 64'(req_q[base+2] - req_q[base+1]), 64'd3);
        repeat (10) @(negedge clk); #1;
        check("sat_total", 64'(out_total_words), 64'd15);
        read_cnt(4'd7, 4'd15, "sat_cnt7");

        // Reset with three requests outstanding
        ret_val = 64'd3;
        issue_req(3);
        check("busy_before_rst", 64'(out_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req",   64'(out_rd_packet_req), 64'd0);
        check("mid_rst_busy",  64'(out_busy),          64'd0);
        check("mid_rst_total", 64'(out_total_words),   64'd0);
        check("mid_rst_cnt",   64'(out_cnt_value),     64'd0);
        check("mid_rst_bad",   64'(out_bad_flow_cnt),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        base = req_q.size();
        repeat (12) @(negedge clk); #1;
        check("post_rst_total", 64'(out_total_words),  64'd0);
        check("post_rst_bad",   64'(out_bad_flow_cnt), 64'd0);
        check("post_rst_noreq", 64'(req_q.size() - base), 64'd0);
        read_cnt(4'd3, 4'd0, "post_rst_cnt3");

        // Buffer empty blocks all requests
        in_rd_gap = 8'd3;
        in_buffer_empty = 1'b1;
        in_enable = 1'b1;
        base = req_q.size();
        repeat (20) @(negedge clk); #1;
        check("empty_noreq", 64'(req_q.size() - base), 64'd0);
        in_enable = 1'b0;
        in_buffer_empty = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wfq_egress_reader.md
WFQ_EGRESS_READER -- requirements
Module: wfq_egress_reader

Interface
REQ-001 Parameter NUM_FLOWS, default 16, number of flows counted (power of two).
REQ-002 Parameter RD_LATENCY, default 7, cycles from read request to valid scheduler output data.
REQ-003 Parameter DATA_W, default 64, scheduler output data width.
REQ-004 Parameter CNT_W, default 32, per-flow and total counter width.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_enable  in  1  permits issuing read requests while high.
REQ-008 in_rd_gap  in  8  minimum idle cycles between read requests; 0 is treated as 1.
REQ-009 in_buffer_empty  in  1  scheduler packet buffer empty flag.
REQ-010 out_rd_packet_req  out  1  single-cycle read request to the scheduler.
REQ-011 in_packet_data  in  DATA_W  scheduler output word.
REQ-012 in_clear  in  1  synchronous clear of all statistics counters.
REQ-013 in_cnt_sel  in  log2(NUM_FLOWS)  flow selected for readback.
REQ-014 out_cnt_value  out  CNT_W  word count of selected flow, registered.
REQ-015 out_total_words  out  CNT_W  total words captured across all valid flows.
REQ-016 out_bad_flow_cnt  out  16  captured words whose value is >= NUM_FLOWS.
REQ-017 out_busy  out  1  high while any issued request still awaits its data.

Function
REQ-018 Request FSM SHALL have three states: IDLE, REQ, GAP.
REQ-019 IDLE -> REQ when in_enable=1 and in_buffer_empty=0 are sampled at the same edge; otherwise stay in IDLE.
REQ-020 REQ SHALL assert out_rd_packet_req for exactly one cycle, latch G=max(in_rd_gap,1), and go to GAP.
REQ-021 GAP SHALL hold out_rd_packet_req=0 for exactly G cycles, then return to IDLE.
REQ-022 Two request pulses SHALL never be adjacent; the minimum period is 2+G cycles including the IDLE cycle.
REQ-023 Deasserting in_enable SHALL stop new requests only; a request already in REQ/GAP completes, and its data is still captured.
REQ-024 A request issued in cycle n SHALL have in_packet_data sampled at the edge ending cycle n+RD_LATENCY, tracked by a RD_LATENCY-deep request shift register.
REQ-025 Captured word value v < NUM_FLOWS: increment counter[v] and out_total_words; otherwise increment out_bad_flow_cnt only.
REQ-026 All counters SHALL saturate at their maximum value and never wrap.
REQ-027 in_clear with a capture in the same cycle: counters are zeroed, then that capture is counted (the affected counters read 1).
REQ-028 out_cnt_value SHALL equal counter[in_cnt_sel] one cycle after in_cnt_sel is applied, and reflect updates one cycle later.
REQ-029 out_busy SHALL be the OR of the request shift register bits.
REQ-030 in_buffer_empty is checked only in IDLE; it has no effect during REQ or GAP.

Reset
REQ-031 rst_n low SHALL force: FSM=IDLE, out_rd_packet_req=0, shift register cleared, out_busy=0, all counters and out_cnt_value=0.
REQ-032 Reset mid-operation SHALL discard outstanding requests; data arriving after reset release SHALL NOT be counted.

Structure
REQ-033 Package wfq_pkg SHALL hold NUM_FLOWS, RD_LATENCY, DATA_W and CNT_W defaults, and the FSM state type.
REQ-034 Counter array, saturation and readback mux SHALL live in sub-module wfq_flow_counter_bank; the FSM and latency tracking stay in wfq_egress_reader.

Verification
REQ-035 Enable=1, empty=0, gap=3: requests at cycles 0,5,10,... -> period exactly 5, never adjacent.
REQ-036 Model returns data 5 at request+7 for 10 requests -> counter[5]=10, total=10, bad=0, out_busy low 8 cycles after the last request.
REQ-037 Data 0x20 with NUM_FLOWS=16 -> bad=1, total unchanged.
REQ-038 in_clear coincides with a capture of flow 2 -> counter[2]=1, total=1.
REQ-039 rst_n low with 3 requests outstanding -> all outputs 0 immediately, no counts after release.
REQ-040 Empty=1 throughout, or gap=0 -> no request issued, or period 3 respectively.
